// File: rtl/sipo_pkg.sv
// Shared types and the shift helper for the SIPO frame deserializer.
// The shift helper works on a fixed-width container so one function serves every frame width.
package sipo_pkg;

  typedef enum logic {
    SIPO_MSB_FIRST = 1'b0,
    SIPO_LSB_FIRST = 1'b1
  } sipo_mode_e;

  // Widest frame the shift helper can carry.
  localparam int unsigned SIPO_MAX_W = 64;

  // Shift one serial bit into the low `width` bits of sr; bits at or above `width` come back zero.
  function automatic logic [SIPO_MAX_W-1:0] sipo_shift(
    input logic [SIPO_MAX_W-1:0] sr,
    input logic                  din,
    input sipo_mode_e            mode,
    input int unsigned           width
  );
    logic [SIPO_MAX_W-1:0] mask;
    logic [SIPO_MAX_W-1:0] sr_m;
    logic [SIPO_MAX_W-1:0] res;
    mask = (width >= SIPO_MAX_W) ? '1
                                 : ((SIPO_MAX_W'(1) << width) - SIPO_MAX_W'(1));
    sr_m = sr & mask;
    if (mode == SIPO_LSB_FIRST) begin
      res = (sr_m >> 1) | (SIPO_MAX_W'(din) << (width - 1));
    end else begin
      res = (sr_m << 1) | SIPO_MAX_W'(din);
    end
    return res & mask;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: counts qualified bits 0..WIDTH-1, wraps, and flags the first and last slot.
module sipo_bit_counter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_frame_deserializer.sv
// Serial-in/parallel-out frame deserializer with selectable bit order, a valid/ready output
// register and a sticky overrun flag.
module sipo_frame_deserializer
  import sipo_pkg::*;
#(
  parameter  int unsigned      WIDTH      = 8,
  parameter  logic [WIDTH-1:0] PRESET_VAL = '1,
  localparam int unsigned      CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             preset,
  input  logic             lsb_first,
  input  logic             s_valid,
  input  logic             s_in,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic             overrun
);

  logic [WIDTH-1:0]      sr_q;
  logic [WIDTH-1:0]      sr_next;
  logic [WIDTH-1:0]      p_out_q;
  logic                  p_valid_q;
  logic                  overrun_q;
  sipo_mode_e            mode_q;
  sipo_mode_e            mode_eff;
  logic [CNT_W-1:0]      count;
  logic                  cnt_zero;
  logic                  cnt_last;
  logic                  complete;
  logic [SIPO_MAX_W-1:0] shift_wide;
  logic                  unused_shift_hi;

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | preset),
    .en    (s_valid),
    .count (count),
    .zero  (cnt_zero),
    .last  (cnt_last)
  );

  // The first bit of a frame already obeys the live lsb_first; later bits use the latched mode.
  assign mode_eff = cnt_zero ? sipo_mode_e'(lsb_first) : mode_q;

  assign shift_wide      = sipo_shift(SIPO_MAX_W'(sr_q), s_in, mode_eff, WIDTH);
  assign sr_next         = shift_wide[WIDTH-1:0];
  assign unused_shift_hi = ^shift_wide;

  assign complete = s_valid && cnt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      mode_q    <= SIPO_MSB_FIRST;
    end else if (clr) begin
      sr_q      <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      mode_q    <= SIPO_MSB_FIRST;
    end else if (preset) begin
      // Abort the partial frame only; the output side keeps its frame and flags.
      sr_q <= PRESET_VAL;
    end else begin
      if (s_valid) begin
        sr_q <= sr_next;
        if (cnt_zero) begin
          mode_q <= mode_eff;
        end
      end
      if (complete) begin
        p_out_q   <= sr_next;
        p_valid_q <= 1'b1;
        if (p_valid_q && !p_ready) begin
          overrun_q <= 1'b1;
        end
      end else if (p_valid_q && p_ready) begin
        p_valid_q <= 1'b0;
      end
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign overrun = overrun_q;
  assign busy    = !cnt_zero;

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Directed bench for sipo_frame_deserializer: an 8-bit instance for the main scenarios and a
// 4-bit instance for the narrow-width rerun.
module tb_sipo_frame_deserializer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       preset;
  logic       lsb_first;
  logic       s_valid;
  logic       s_in;
  logic       p_ready;
  logic [7:0] p_out;
  logic       p_valid;
  logic       busy;
  logic       overrun;

  logic       s_valid4;
  logic       s_in4;
  logic [3:0] p_out4;
  logic       p_valid4;
  logic       busy4;
  logic       overrun4;

  int checks;
  int errors;

  sipo_frame_deserializer #(
    .WIDTH      (8),
    .PRESET_VAL (8'hFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .preset    (preset),
    .lsb_first (lsb_first),
    .s_valid   (s_valid),
    .s_in      (s_in),
    .p_ready   (p_ready),
    .p_out     (p_out),
    .p_valid   (p_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  sipo_frame_deserializer #(
    .WIDTH      (4),
    .PRESET_VAL (4'hF)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .preset    (preset),
    .lsb_first (lsb_first),
    .s_valid   (s_valid4),
    .s_in      (s_in4),
    .p_ready   (p_ready),
    .p_out     (p_out4),
    .p_valid   (p_valid4),
    .busy      (busy4),
    .overrun   (overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_in    = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_bit4(input logic b);
    s_valid4 = 1'b1;
    s_in4    = b;
    tick();
    s_valid4 = 1'b0;
  endtask

  // Bits go out in the order v[7] .. v[0].
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic test_reset();
    checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL reset_p_out got %h want 00", p_out); end
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid got %b want 0", p_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (p_out4 !== 4'h0) begin errors++; $display("FAIL reset_p_out4 got %h want 0", p_out4); end
  endtask

  task automatic test_msb_first();
    lsb_first = 1'b0;
    p_ready   = 1'b1;
    send_bit(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy_mid got %b want 1", busy); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL msb_p_valid_early got %b want 0", p_valid); end
    send_bit(1'b0);
    checks++; if (p_out !== 8'hB2) begin errors++; $display("FAIL msb_p_out got %h want b2", p_out); end
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL msb_p_valid got %b want 1", p_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_after got %b want 0", busy); end
    tick();
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL msb_p_valid_1cyc got %b want 0", p_valid); end
  endtask

  task automatic test_lsb_gaps();
    lsb_first = 1'b1;
    p_ready   = 1'b1;
    send_bit(1'b1);
    lsb_first = 1'b0;
    send_bit(1'b0);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsb_busy_gap got %b want 1", busy); end
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL lsb_p_valid_gap got %b want 0", p_valid); end
    send_bit(1'b1); send_bit(1'b1);
    lsb_first = 1'b1;
    tick(); tick();
    lsb_first = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    checks++; if (p_out !== 8'h4D) begin errors++; $display("FAIL lsb_p_out got %h want 4d", p_out); end
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL lsb_p_valid got %b want 1", p_valid); end
    tick();
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL lsb_p_valid_acc got %b want 0", p_valid); end
  endtask

  task automatic test_overrun_clr();
    p_ready   = 1'b0;
    lsb_first = 1'b0;
    send_byte(8'hA5);
    checks++; if (p_out !== 8'hA5) begin errors++; $display("FAIL ovr_first_p_out got %h want a5", p_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_overrun got %b want 0", overrun); end
    send_byte(8'h3C);
    checks++; if (p_out !== 8'h3C) begin errors++; $display("FAIL ovr_p_out got %h want 3c", p_out); end
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL ovr_p_valid got %b want 1", p_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_overrun got %b want 1", overrun); end
    send_bit(1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL clr_p_out got %h want 00", p_out); end
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL clr_p_valid got %b want 0", p_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    p_ready = 1'b0;
    send_byte(8'h5A);
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", p_valid); end
    // 8'hC3 = 1100_0011; hold p_ready low until the completing bit.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    checks++; if (p_out !== 8'h5A) begin errors++; $display("FAIL b2b_hold_p_out got %h want 5a", p_out); end
    p_ready = 1'b1;
    send_bit(1'b1);
    checks++; if (p_out !== 8'hC3) begin errors++; $display("FAIL b2b_p_out got %h want c3", p_out); end
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL b2b_p_valid got %b want 1", p_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    tick();
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b want 0", p_valid); end
  endtask

  task automatic test_preset();
    p_ready = 1'b0;
    send_byte(8'h81);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL preset_busy_before got %b want 1", busy); end
    // A bit offered on the preset edge must be dropped.
    preset  = 1'b1;
    s_valid = 1'b1;
    s_in    = 1'b1;
    tick();
    preset  = 1'b0;
    s_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL preset_busy got %b want 0", busy); end
    checks++; if (p_out !== 8'h81) begin errors++; $display("FAIL preset_p_out got %h want 81", p_out); end
    checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL preset_p_valid got %b want 1", p_valid); end
    p_ready = 1'b1;
    tick();
    send_byte(8'h0F);
    checks++; if (p_out !== 8'h0F) begin errors++; $display("FAIL preset_frame got %h want 0f", p_out); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL preset_overrun got %b want 0", overrun); end
    tick();
  endtask

  task automatic test_async_reset_and_w4();
    p_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before got %b want 1", busy); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL arst_p_out got %h want 00", p_out); end
    checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL arst_p_valid got %b want 0", p_valid); end
    #2;
    rst_n = 1'b1;
    tick();
    lsb_first = 1'b0;
    p_ready   = 1'b1;
    send_bit4(1'b1); send_bit4(1'b0); send_bit4(1'b1);
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL w4_busy_mid got %b want 1", busy4); end
    send_bit4(1'b1);
    checks++; if (p_out4 !== 4'hB) begin errors++; $display("FAIL w4_p_out got %h want b", p_out4); end
    checks++; if (p_valid4 !== 1'b1) begin errors++; $display("FAIL w4_p_valid got %b want 1", p_valid4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL w4_busy_after got %b want 0", busy4); end
    tick();
    checks++; if (p_valid4 !== 1'b0) begin errors++; $display("FAIL w4_accept got %b want 0", p_valid4); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    preset    = 1'b0;
    lsb_first = 1'b0;
    s_valid   = 1'b0;
    s_in      = 1'b0;
    p_ready   = 1'b0;
    s_valid4  = 1'b0;
    s_in4     = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_msb_first();
    test_lsb_gaps();
    test_overrun_clr();
    test_back_to_back();
    test_preset();
    test_async_reset_and_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
